if_id_skid_reg: RTL
===================

# if_id_skid_reg

Parametrised IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer. It sits between the fetch stage and the decode stage and carries PC and instruction at full throughput. Downstream back-pressure stalls fetch without a combinational ready path. A jump/branch flush squashes in-flight instructions to NOP.

## Interface
- PC_W, 8, PC width in bits
- INSTR_W, 8, instruction width in bits
- NOP_INSTR, 0, encoding driven on instr_out whenever the stage holds no valid beat
- CNT_W, 16, width of the performance counters
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  squash all held and incoming instructions (jump/branch taken)
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage can accept a beat; registered
- pc_in  in  PC_W  fetched PC
- instr_in  in  INSTR_W  fetched instruction
- out_valid  out  1  decode-side beat valid
- out_ready  in  1  decode accepts the beat
- pc_out  out  PC_W  PC to decode
- instr_out  out  INSTR_W  instruction to decode
- stall_cnt  out  CNT_W  back-pressure cycle count (IF_ID_PERF_EN)
- flush_cnt  out  CNT_W  flush cycle count (IF_ID_PERF_EN)

## Operation
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Storage is a main register (drives the outputs) and a skid register. in_ready = !skid_valid, taken directly from a flop.
- EMPTY (main and skid invalid):
  - input accept -> ONE, main <= input.
- ONE (main valid, skid invalid):
  - accept & out_ready -> ONE, main <= input.
  - accept & !out_ready -> TWO, skid <= input.
  - no accept & out_ready -> EMPTY.
  - otherwise hold.
- TWO (both valid, in_ready=0):
  - out_ready -> ONE, main <= skid, skid invalid.
  - otherwise hold; no payload changes.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush/rst.
- Flush:
  - Clears main and skid valid; next state is EMPTY.
  - A beat handshaken in the flush cycle is discarded.
  - Takes priority over every other transition.
- rst has priority over flush.
- Invalid payload: whenever out_valid=0, pc_out=0 and instr_out=NOP_INSTR. Payload is forced at every transition to EMPTY, including drain.

## Timing
- Reset values: out_valid=0, in_ready=1, pc_out=0, instr_out=NOP_INSTR, stall_cnt=0, flush_cnt=0; internal skid invalid.
- Latency: 1 cycle. A beat accepted at edge N is on the outputs after edge N.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready drops the cycle after the skid fills. It rises the cycle after the skid drains.
- No combinational path from out_ready to in_ready, or from inputs to outputs.
- Flush at edge N: out_valid=0, in_ready=1 after edge N. A beat accepted at edge N+1 appears after N+1.
- rst mid-operation: same as flush; counters also cleared.
- Simultaneous flush & rst: reset values.

## Configuration
- IF_ID_PERF_EN defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle with flush=1 (rst=0).
  - Both counters saturate at all-ones.
  - Cleared only by rst, not by flush.
- IF_ID_PERF_EN undefined: stall_cnt and flush_cnt tied to 0 and no counter flops exist. Handshake behaviour is identical.

## Test plan
- Reset, then stream pc 0x10..0x13 / instr 0xA0..0xA3 with out_ready=1 -> outputs follow one cycle later, one per cycle, in_ready stays 1.
- ONE with 0x10/0xA0, out_ready=0, in_valid with 0x11/0xA1:
  - 0x11 captured in skid; in_ready=0 next cycle.
  - Raise out_ready -> 0xA0 then 0xA1 delivered; in_ready returns to 1.
- TWO state, flush=1 with in_valid=1 -> out_valid=0, instr_out=NOP_INSTR, pc_out=0, in_ready=1 next cycle; neither held beat nor input ever appears.
- rst asserted while TWO and out_ready=0 -> all reset values after the edge; in_ready=1.
- With IF_ID_PERF_EN: hold out_valid=1, out_ready=0 for 5 cycles, then 2 flush cycles -> stall_cnt=5, flush_cnt=2. With CNT_W=2 and 6 stall cycles -> stall_cnt=3 (saturated).
- Without IF_ID_PERF_EN: same stimulus -> both counters 0, data identical.

Source files
------------

// File: rtl/if_id_skid_reg_if.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg_if
// Fetch-to-decode handshake bundle for the IF/ID skid register: the upstream
// (fetch) valid/ready/payload and the downstream (decode) valid/ready/payload.
// The master modport is the environment around the stage (fetch + decode);
// the slave modport is the stage itself.
// ----------------------------------------------------------------------------
interface if_id_skid_reg_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  // Fetch side
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;

  // Decode side
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;

  modport master (
    output in_valid, pc_in, instr_in, out_ready,
    input  in_ready, out_valid, pc_out, instr_out
  );

  modport slave (
    input  in_valid, pc_in, instr_in, out_ready,
    output in_ready, out_valid, pc_out, instr_out
  );
endinterface : if_id_skid_reg_if

// File: rtl/if_id_skid_reg.sv
// ----------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline register with a two-entry skid buffer. The main register
// drives decode; the skid register catches the one beat fetch may still send
// in the cycle decode stalls, so in_ready can come straight from a flop with
// no combinational path from out_ready. A flush squashes everything held and
// anything handshaken in the same cycle; rst has priority over flush.
//
// Optional feature: define IF_ID_PERF_EN to build saturating stall/flush
// performance counters. Without it the counter outputs are tied to zero and
// no counter flops exist.
// ----------------------------------------------------------------------------
module if_id_skid_reg #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  if_id_skid_reg_if.slave     bus,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main and skid invalid
    ST_ONE   = 2'd1,  // main valid, skid invalid
    ST_TWO   = 2'd2   // main and skid valid, fetch stalled
  } state_e;

  state_e             state_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic [PC_W-1:0]    main_pc_q;
  logic [INSTR_W-1:0] main_instr_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  logic               accept;
  logic               skid_load;

  // Input handshake uses the registered ready, so no out_ready -> in_ready path.
  assign accept    = bus.in_valid & in_ready_q;

  // Skid captures a beat only when main is busy and decode is stalling.
  assign skid_load = !rst && !flush && (state_q == ST_ONE) && accept && !bus.out_ready;

  // Control FSM and main register: occupancy, registered handshake outputs
  // and the payload presented to decode.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
    end else if (flush) begin
      // Squash held beats and discard any beat handshaken this cycle.
      state_q      <= ST_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q      <= ST_ONE;
            out_valid_q  <= 1'b1;
            main_pc_q    <= bus.pc_in;
            main_instr_q <= bus.instr_in;
          end
        end

        ST_ONE: begin
          if (accept && bus.out_ready) begin
            // Full-throughput pass: old beat leaves, new beat replaces it.
            main_pc_q    <= bus.pc_in;
            main_instr_q <= bus.instr_in;
          end else if (accept) begin
            // Decode stalled: new beat parks in the skid, fetch stops next cycle.
            state_q      <= ST_TWO;
            in_ready_q   <= 1'b0;
          end else if (bus.out_ready) begin
            // Drain to empty; payload returns to the idle encoding.
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
          end
        end

        ST_TWO: begin
          if (bus.out_ready) begin
            // Main retires; the skid beat moves up and fetch is released.
            state_q      <= ST_ONE;
            in_ready_q   <= 1'b1;
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
          end
        end

        default: begin
          state_q      <= ST_EMPTY;
          out_valid_q  <= 1'b0;
          in_ready_q   <= 1'b1;
          main_pc_q    <= '0;
          main_instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

  // Skid payload: loaded only when it becomes the second held beat.
  // NOTE: the skid payload has no reset; it is only ever read while the FSM
  // says it holds a valid beat, so leaving it unreset saves reset routing.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_pc_q    <= bus.pc_in;
      skid_instr_q <= bus.instr_in;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pc_out    = main_pc_q;
  assign bus.instr_out = main_instr_q;

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating next-state for both counters; flush does not clear them.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers; cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  // Structural invariants of the occupancy encoding.
  a_idle_payload : assert property (@(posedge clk) disable iff (rst)
    !out_valid_q |-> (main_pc_q == '0 && main_instr_q == NOP_INSTR));
  a_stall_implies_full : assert property (@(posedge clk) disable iff (rst)
    !in_ready_q |-> out_valid_q);

endmodule : if_id_skid_reg
